// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the processor/router flit path.
//   FLIT_W     : flit width, {tlast, payload[7:0]}
//   TLAST_BIT  : bit position of tlast inside a flit
//   state_e    : receive FSM states (IDLE, RECV, DONE)
//   SEQ_FIRST  : first payload value of every burst
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W    = 9;
  localparam int TLAST_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SEQ_FIRST = 1;

endpackage : noc_pkg

// File: rtl/seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
// Tracks the expected payload value and the running length of the burst
// being received. Both counters advance 1,2,...,max and then wrap back to 1,
// never passing through 0, matching the sender's overflow rule.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   accept_i    in   a flit is transferred this cycle
//   start_i     in   the flit (if any) opens a new burst
//   payload_i   in   payload of the flit presented this cycle
//   mismatch_o  out  payload differs from the expected sequence value
//   next_len_o  out  burst length including the flit presented this cycle
// -----------------------------------------------------------------------------
module seq_checker
  import noc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accept_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] payload_i,
  output logic              mismatch_o,
  output logic [DATA_W-1:0] next_len_o
);

  localparam logic [DATA_W-1:0] FIRST = DATA_W'(SEQ_FIRST);

  // Increment with the all-ones -> 1 wrap; 0 is never produced.
  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? FIRST : v + DATA_W'(1);
  endfunction

  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] cur_exp;

  // A new burst restarts both counters, so the first flit is compared
  // against FIRST regardless of what the previous burst left behind.
  always_comb begin
    cur_exp    = start_i ? FIRST : exp_q;
    mismatch_o = (payload_i != cur_exp);
    next_len_o = start_i ? FIRST : wrap_inc(len_q);
    exp_d      = exp_q;
    len_d      = len_q;
    if (accept_i) begin
      exp_d = wrap_inc(cur_exp);
      len_d = next_len_o;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q <= FIRST;
      len_q <= '0;
    end else begin
      exp_q <= exp_d;
      len_q <= len_d;
    end
  end

endmodule : seq_checker

// File: rtl/flit_sink.sv
// -----------------------------------------------------------------------------
// flit_sink
// Receive end of the processor-to-router flit stream. Consumes flits
// {tlast, payload}, checks that payloads count 1,2,3,... within a burst and
// that the final length matches expected_len, and reports every completed
// burst through a level-held done/ack handshake.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   flit_valid    in   flit_data holds a flit
//   flit_data     in   [DATA_W] = tlast, [DATA_W-1:0] = sequence payload
//   flit_ready    out  sink accepts a flit (registered, 0 while DONE)
//   expected_len  in   expected burst length, 0 disables the length check
//   burst_ack     in   consumer has read the burst result
//   burst_done    out  completed-burst result valid, held until acked
//   burst_len     out  number of flits in the completed burst
//   seq_error     out  sticky per burst: out-of-order payload seen
//   len_error     out  completed burst length differs from expected_len
//   data_got      out  last accepted flit
//   busy          out  a burst is in progress
//   burst_count   out  total completed bursts (wraps)
//   error_count   out  total bursts with any error (wraps)
// -----------------------------------------------------------------------------
module flit_sink
  import noc_pkg::*;
#(
  parameter int DATA_W = TLAST_BIT,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flit_valid,
  input  logic [DATA_W:0]   flit_data,
  output logic              flit_ready,
  input  logic [DATA_W-1:0] expected_len,
  input  logic              burst_ack,
  output logic              burst_done,
  output logic [DATA_W-1:0] burst_len,
  output logic              seq_error,
  output logic              len_error,
  output logic [DATA_W:0]   data_got,
  output logic              busy,
  output logic [CNT_W-1:0]  burst_count,
  output logic [CNT_W-1:0]  error_count
);

  state_e            state_q;
  logic              flit_ready_q;
  logic              burst_done_q;
  logic [DATA_W-1:0] burst_len_q;
  logic              seq_error_q;
  logic              len_error_q;
  logic [DATA_W:0]   data_got_q;
  logic              busy_q;
  logic [CNT_W-1:0]  burst_count_q;
  logic [CNT_W-1:0]  error_count_q;

  logic              accept;
  logic              start;
  logic              tlast;
  logic              mismatch;
  logic [DATA_W-1:0] next_len;
  logic              seq_error_d;
  logic              len_error_d;

  // flit_ready is a registered copy of "not in DONE", so accept never
  // depends combinationally on anything the sink computes this cycle.
  assign accept = flit_valid & flit_ready_q;
  assign start  = (state_q == ST_IDLE);
  assign tlast  = flit_data[DATA_W];

  seq_checker #(
    .DATA_W (DATA_W)
  ) u_seq (
    .clock      (clock),
    .reset      (reset),
    .accept_i   (accept),
    .start_i    (start),
    .payload_i  (flit_data[DATA_W-1:0]),
    .mismatch_o (mismatch),
    .next_len_o (next_len)
  );

  // Error flags as they stand after the flit presented this cycle. The
  // first flit of a burst overwrites whatever the previous burst left.
  always_comb begin
    seq_error_d = start ? mismatch : (seq_error_q | mismatch);
    len_error_d = (expected_len != '0) && (next_len != expected_len);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      flit_ready_q  <= 1'b1;
      burst_done_q  <= 1'b0;
      burst_len_q   <= '0;
      seq_error_q   <= 1'b0;
      len_error_q   <= 1'b0;
      data_got_q    <= '0;
      busy_q        <= 1'b0;
      burst_count_q <= '0;
      error_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RECV: begin
          if (accept) begin
            data_got_q  <= flit_data;
            seq_error_q <= seq_error_d;
            if (tlast) begin
              // Burst complete: latch result and update statistics on the
              // same edge that accepts the tlast flit.
              state_q       <= ST_DONE;
              flit_ready_q  <= 1'b0;
              busy_q        <= 1'b0;
              burst_done_q  <= 1'b1;
              burst_len_q   <= next_len;
              len_error_q   <= len_error_d;
              burst_count_q <= burst_count_q + CNT_W'(1);
              error_count_q <= error_count_q + CNT_W'(seq_error_d | len_error_d);
            end else begin
              state_q <= ST_RECV;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (burst_ack) begin
            state_q      <= ST_IDLE;
            flit_ready_q <= 1'b1;
            burst_done_q <= 1'b0;
            seq_error_q  <= 1'b0;
            len_error_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          flit_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign flit_ready  = flit_ready_q;
  assign burst_done  = burst_done_q;
  assign burst_len   = burst_len_q;
  assign seq_error   = seq_error_q;
  assign len_error   = len_error_q;
  assign data_got    = data_got_q;
  assign busy        = busy_q;
  assign burst_count = burst_count_q;
  assign error_count = error_count_q;

endmodule : flit_sink

// File: tb/tb_flit_sink.sv
// -----------------------------------------------------------------------------
// tb_flit_sink
// Drives directed and randomized bursts into flit_sink and compares every
// output each cycle against a burst-level model (a queue of received
// payloads), plus literal expectations at hand-picked points.
// -----------------------------------------------------------------------------
module tb_flit_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flit_valid = 1'b0;
  logic [8:0]  flit_data = '0;
  logic [7:0]  expected_len = '0;
  logic        burst_ack = 1'b0;
  logic        flit_ready;
  logic        burst_done;
  logic [7:0]  burst_len;
  logic        seq_error;
  logic        len_error;
  logic [8:0]  data_got;
  logic        busy;
  logic [15:0] burst_count;
  logic [15:0] error_count;

  flit_sink #(.DATA_W(8), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .flit_valid   (flit_valid),
    .flit_data    (flit_data),
    .flit_ready   (flit_ready),
    .expected_len (expected_len),
    .burst_ack    (burst_ack),
    .burst_done   (burst_done),
    .burst_len    (burst_len),
    .seq_error    (seq_error),
    .len_error    (len_error),
    .data_got     (data_got),
    .busy         (busy),
    .burst_count  (burst_count),
    .error_count  (error_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int lit_tag = 0;
  int lit_seq = 0;
  int lit_seen = 0;
  int timeouts = 0;

  // ---------------- behavioural model ----------------
  bit          m_ready = 1'b1;
  bit          m_done = 1'b0;
  bit          m_seq = 1'b0;
  bit          m_lenerr = 1'b0;
  bit          m_busy = 1'b0;
  logic [7:0]  m_len = '0;
  logic [8:0]  m_data = '0;
  logic [15:0] m_bcnt = '0;
  logic [15:0] m_ecnt = '0;
  int          pay_q[$];
  int          m_n;

  // Payload i (0-based) of a burst must equal (i mod 255) + 1.
  function automatic bit any_bad();
    for (int i = 0; i < pay_q.size(); i++)
      if (pay_q[i] != (i % 255) + 1) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ready = 1'b1; m_done = 1'b0; m_seq = 1'b0; m_lenerr = 1'b0;
      m_busy = 1'b0; m_len = '0; m_data = '0; m_bcnt = '0; m_ecnt = '0;
      pay_q.delete();
    end else if (flit_valid && m_ready) begin
      m_data = flit_data;
      pay_q.push_back(int'(flit_data[7:0]));
      m_seq = any_bad();
      if (flit_data[8]) begin
        m_n      = pay_q.size();
        m_len    = 8'(((m_n - 1) % 255) + 1);
        m_lenerr = (expected_len != 8'd0) && (m_len != expected_len);
        m_bcnt   = m_bcnt + 16'd1;
        if (m_seq || m_lenerr) m_ecnt = m_ecnt + 16'd1;
        m_done = 1'b1; m_ready = 1'b0; m_busy = 1'b0;
        pay_q.delete();
      end else begin
        m_busy = 1'b1;
      end
    end else if (m_done && burst_ack) begin
      m_done = 1'b0; m_seq = 1'b0; m_lenerr = 1'b0; m_ready = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("flit_ready",  32'(flit_ready),  32'(m_ready));
      chk("burst_done",  32'(burst_done),  32'(m_done));
      chk("burst_len",   32'(burst_len),   32'(m_len));
      chk("seq_error",   32'(seq_error),   32'(m_seq));
      chk("len_error",   32'(len_error),   32'(m_lenerr));
      chk("data_got",    32'(data_got),    32'(m_data));
      chk("busy",        32'(busy),        32'(m_busy));
      chk("burst_count", 32'(burst_count), 32'(m_bcnt));
      chk("error_count", 32'(error_count), 32'(m_ecnt));
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      case (lit_tag)
        1: begin
          chk("t1_done", 32'(burst_done), 32'd1);
          chk("t1_len",  32'(burst_len),  32'd4);
          chk("t1_seq",  32'(seq_error),  32'd0);
          chk("t1_lerr", 32'(len_error),  32'd0);
          chk("t1_bcnt", 32'(burst_count), 32'd1);
        end
        2: begin
          chk("t2_seq",  32'(seq_error),   32'd1);
          chk("t2_ecnt", 32'(error_count), 32'd1);
          chk("t2_len",  32'(burst_len),   32'd4);
        end
        3: chk("t3_lerr_exp5", 32'(len_error), 32'd1);
        4: chk("t4_lerr_exp0", 32'(len_error), 32'd0);
        5: begin
          chk("t5_len",   32'(burst_len),  32'd1);
          chk("t5_done",  32'(burst_done), 32'd1);
          chk("t5_ready", 32'(flit_ready), 32'd0);
        end
        6: chk("t6_data_got", 32'(data_got), 32'h001);
        7: begin
          chk("t7_len", 32'(burst_len), 32'd1);
          chk("t7_seq", 32'(seq_error), 32'd0);
        end
        8: begin
          chk("t8_done",  32'(burst_done),  32'd0);
          chk("t8_ready", 32'(flit_ready),  32'd1);
          chk("t8_bcnt",  32'(burst_count), 32'd0);
          chk("t8_ecnt",  32'(error_count), 32'd0);
          chk("t8_data",  32'(data_got),    32'd0);
          chk("t8_busy",  32'(busy),        32'd0);
        end
        9: begin
          chk("t9_len",  32'(burst_len),   32'd2);
          chk("t9_bcnt", 32'(burst_count), 32'd1);
        end
        10: chk("wait_timeouts", 32'(timeouts), 32'd0);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input int tag);
    #1;
    lit_tag = tag;
    lit_seq = lit_seq + 1;
  endtask

  task automatic send(input logic [8:0] f, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      flit_valid = 1'b0;
      burst_ack  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clock);
    burst_ack  = 1'b0;
    flit_valid = 1'b1;
    flit_data  = f;
    t = 0;
    while (!flit_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      timeouts++;
      $display("FAIL send_timeout flit=%0h", f);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    flit_valid = 1'b0;
    burst_ack  = 1'b0;
  endtask

  task automatic ack(input int dly);
    int t;
    repeat (dly) @(negedge clock);
    t = 0;
    while (!burst_done && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      timeouts++;
      $display("FAIL ack_timeout");
    end
    @(negedge clock);
    burst_ack = 1'b1;
    @(negedge clock);
    burst_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int blen;
    logic [7:0] pay;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Directed: clean 4-flit burst
    expected_len = 8'd4;
    send(9'h001, 0); send(9'h002, 0); send(9'h003, 0); send(9'h104, 0);
    idle(); lit(1); ack(1);
    $display("burst 1: clean 4-flit");

    // Out-of-order payload
    send(9'h001, 0); send(9'h002, 0); send(9'h005, 0); send(9'h104, 0);
    idle(); lit(2); ack(0);
    $display("burst 2: seq error");

    // Length mismatch, then length check disabled
    expected_len = 8'd5;
    send(9'h001, 0); send(9'h002, 0); send(9'h103, 0);
    idle(); lit(3); ack(0);
    $display("burst 3: len error exp=5");
    expected_len = 8'd0;
    send(9'h001, 0); send(9'h002, 0); send(9'h103, 0);
    idle(); lit(4); ack(0);
    $display("burst 4: len check disabled");

    // Single-flit burst; flit held while DONE must not be accepted
    send(9'h101, 0);
    @(negedge clock);
    flit_valid = 1'b1; flit_data = 9'h001;
    lit(5);
    repeat (5) @(negedge clock);
    burst_ack = 1'b1;
    @(negedge clock);
    burst_ack = 1'b0;
    lit(6);
    send(9'h102, 0);
    idle(); ack(0);
    $display("burst 5/6: single flit, hold, ack then accept");

    // 256-flit burst exercising the 255 -> 1 wrap
    for (int i = 1; i <= 255; i++) send({1'b0, 8'(i)}, 0);
    send(9'h101, 0);
    idle(); lit(7); ack(0);
    $display("burst 7: 256-flit wrap");

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      blen = $urandom_range(1, 12);
      case ($urandom_range(0, 2))
        0: expected_len = 8'd0;
        1: expected_len = 8'(blen);
        default: expected_len = 8'($urandom_range(1, 15));
      endcase
      for (int i = 0; i < blen; i++) begin
        pay = 8'(i + 1);
        if ($urandom_range(0, 14) == 0) pay = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) expected_len = 8'($urandom_range(0, 15));
        send({(i == blen - 1), pay}, $urandom_range(0, 2));
      end
      idle();
      ack($urandom_range(0, 3));
      $display("random burst %0d len=%0d exp=%0d count=%0d", b, blen, expected_len, burst_count);
    end

    // Reset in the middle of a burst
    expected_len = 8'd0;
    send(9'h001, 0); send(9'h002, 0);
    @(negedge clock);
    flit_valid = 1'b0;
    #2 reset = 1'b0;
    lit(8);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    send(9'h001, 0); send(9'h102, 0);
    idle(); lit(9);
    $display("burst after reset: 2 flits");
    ack(0);

    @(negedge clock);
    lit(10);
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_flit_sink
